// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard
// using the host-request sequence: clock inhibit, start bit, 8 data bits
// LSB first, odd parity, stop bit, then samples the device ACK. The PS/2
// lines are open-drain, so this block only requests "pull low" or "release".
//
// Ports:
//   Fast_Clock         system clock, all logic on rising edge
//   Raw_Reset_I        asynchronous reset, active-low
//   Send               start request, only honoured in IDLE
//   Tx_Byte[7:0]       byte to send, captured when Send is accepted
//   KB_Clk             PS/2 clock pin level (asynchronous)
//   KB_Data            PS/2 data pin level (asynchronous)
//   KB_Clk_Drive_Low   1 = pull clock pin low, 0 = release
//   KB_Data_Drive_Low  1 = pull data pin low, 0 = release
//   Busy               frame in progress; receive path ignores the bus
//   Done               one-cycle pulse at the end of every accepted frame
//   Ack_Err            device did not ACK; held until next accepted Send
//   Timeout_Err        device clock timeout; held until next accepted Send
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 5000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
  input  logic       Fast_Clock,
  input  logic       Raw_Reset_I,
  input  logic       Send,
  input  logic [7:0] Tx_Byte,
  input  logic       KB_Clk,
  input  logic       KB_Data,
  output logic       KB_Clk_Drive_Low,
  output logic       KB_Data_Drive_Low,
  output logic       Busy,
  output logic       Done,
  output logic       Ack_Err,
  output logic       Timeout_Err
);

  // One shared cycle counter serves the inhibit period and both timeouts.
  localparam int MAX_A   = (INHIBIT_CYCLES > BIT_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : BIT_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > START_TIMEOUT_CYCLES) ? MAX_A : START_TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_EDGE = 3'd3,
    ST_WAIT_IDLE = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t          state_r;
  logic            clk_meta_r;
  logic            clk_sync_r;
  logic            clk_prev_r;
  logic            data_meta_r;
  logic            data_sync_r;
  logic [9:0]      shift_r;      // {stop, parity, byte}, shifted out LSB first
  logic [3:0]      bit_cnt_r;    // device clock falling edges seen this frame
  logic [CW-1:0]   cnt_r;
  logic            clk_drive_r;
  logic            data_drive_r;
  logic            busy_r;
  logic            done_r;
  logic            ack_err_r;
  logic            timeout_err_r;
  logic            fall_s;
  logic [CW-1:0]   edge_limit_s;

  assign fall_s = clk_prev_r & ~clk_sync_r;

  // Pick the edge timeout: the first device edge gets the longer start limit.
  always_comb begin
    edge_limit_s = BIT_LAST;
    if (bit_cnt_r == 4'd0) begin
      edge_limit_s = START_LAST;
    end else begin
      edge_limit_s = BIT_LAST;
    end
  end

  // Two-flop synchronizers for both pins plus the delayed clock for edge detect.
  always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
    if (!Raw_Reset_I) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= KB_Clk;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= KB_Data;
      data_sync_r <= data_meta_r;
    end
  end

  // Frame sequencer; every output is a register updated together with the state.
  always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
    if (!Raw_Reset_I) begin
      state_r       <= ST_IDLE;
      shift_r       <= 10'd0;
      bit_cnt_r     <= 4'd0;
      cnt_r         <= CNT_ZERO;
      clk_drive_r   <= 1'b0;
      data_drive_r  <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      ack_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Send) begin
            shift_r       <= {1'b1, odd_parity(Tx_Byte), Tx_Byte};
            ack_err_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b1;
            clk_drive_r   <= 1'b1;
            data_drive_r  <= 1'b0;
            cnt_r         <= CNT_ZERO;
            state_r       <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt_r == INH_LAST) begin
            data_drive_r <= 1'b1;
            cnt_r        <= CNT_ZERO;
            state_r      <= ST_START;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_START: begin
          // Releasing the clock with data held low presents the start bit.
          clk_drive_r <= 1'b0;
          bit_cnt_r   <= 4'd0;
          cnt_r       <= CNT_ZERO;
          state_r     <= ST_WAIT_EDGE;
        end
        ST_WAIT_EDGE: begin
          if (fall_s) begin
            cnt_r <= CNT_ZERO;
            if (bit_cnt_r == 4'd10) begin
              // Device pulls data low for ACK; a high level means no ACK.
              ack_err_r    <= data_sync_r;
              data_drive_r <= 1'b0;
              state_r      <= ST_WAIT_IDLE;
            end else begin
              // Edges 0..9 put out data, parity, then the stop bit (release).
              data_drive_r <= ~shift_r[0];
              shift_r      <= {1'b0, shift_r[9:1]};
              bit_cnt_r    <= bit_cnt_r + 4'd1;
            end
          end else if (cnt_r == edge_limit_s) begin
            clk_drive_r   <= 1'b0;
            data_drive_r  <= 1'b0;
            timeout_err_r <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b1;
            state_r       <= ST_FINISH;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_sync_r && data_sync_r) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_FINISH;
          end else if (cnt_r == BIT_LAST) begin
            timeout_err_r <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b1;
            state_r       <= ST_FINISH;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_FINISH: begin
          // Send is deliberately not looked at here; only IDLE accepts it.
          clk_drive_r  <= 1'b0;
          data_drive_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          clk_drive_r  <= 1'b0;
          data_drive_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign KB_Clk_Drive_Low  = clk_drive_r;
  assign KB_Data_Drive_Low = data_drive_r;
  assign Busy              = busy_r;
  assign Done              = done_r;
  assign Ack_Err           = ack_err_r;
  assign Timeout_Err       = timeout_err_r;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It is the outgoing direction of the keyboard interface, paired with the existing PS/2 receive path inside the IO block. It sends one command byte to the keyboard (for example 0xED set-LEDs, 0xFF reset) using the host-request sequence: clock inhibit, start, 8 data bits LSB first, odd parity, stop, device ACK. The PS/2 lines are open-drain: the block only ever drives them low or releases them. Its Busy output tells the receive path to ignore the bus while a frame is in flight.

Parameters:
INHIBIT_CYCLES, 5000, Fast_Clock cycles the clock line is held low before the start bit (100 us at 50 MHz).
START_TIMEOUT_CYCLES, 750000, maximum wait after releasing the clock for the device's first falling edge (15 ms).
BIT_TIMEOUT_CYCLES, 100000, maximum gap between consecutive device clock falling edges, and the wait for bus idle after ACK (2 ms).

Ports:
Fast_Clock  in  1  system clock, all logic on rising edge
Raw_Reset_I  in  1  asynchronous reset, active-low
Send  in  1  start request, sampled in IDLE only
Tx_Byte  in  8  byte to send, captured when Send is accepted
KB_Clk  in  1  PS/2 clock pin level, asynchronous
KB_Data  in  1  PS/2 data pin level, asynchronous
KB_Clk_Drive_Low  out  1  1 = pull clock pin low, 0 = release
KB_Data_Drive_Low  out  1  1 = pull data pin low, 0 = release
Busy  out  1  frame in progress; receive path must ignore the bus while high
Done  out  1  one-cycle pulse at end of every accepted frame, success or error
Ack_Err  out  1  device did not ACK; held until the next accepted Send
Timeout_Err  out  1  device clock timeout; held until the next accepted Send

Behaviour:
- Reset (Raw_Reset_I = 0, asynchronous, including mid-frame):
  - state = IDLE.
  - Both drive outputs = 0, so the lines are released immediately.
  - Busy, Done, Ack_Err, Timeout_Err = 0.
  - Counters and synchronizers cleared; synchronizers reset to 1.
- Input sync: KB_Clk and KB_Data each pass through 2 flops. Falling edge = previous synced clock 1, current 0. Edge detection lags the pin by 3 cycles.
- Parity = ~^Tx_Byte (odd parity). Shift register holds {stop=1, parity, byte}.
- IDLE:
  - Send = 1 → capture Tx_Byte, clear both error flags, Busy = 1 from the next cycle, go to INHIBIT.
  - Send is accepted even while the device is transmitting. The host overrides; the device retransmits later.
- INHIBIT: clock line low, data released, for exactly INHIBIT_CYCLES cycles → START.
- START: clock low and data low for 1 cycle → WAIT_EDGE. Clock is released from then on; data stays low (this is the start bit).
- WAIT_EDGE / bit counter n = 0..10. On each device-clock falling edge:
  - n = 0..7: data_drive_low = ~bit[n].
  - n = 8: data_drive_low = ~parity.
  - n = 9: release data (stop bit).
  - n = 10: sample synced KB_Data. 0 = ACK; 1 → set Ack_Err. Go to WAIT_IDLE either way.
- Timeout counter:
  - Cleared on every falling edge and on each state entry.
  - Before the first edge, the limit is START_TIMEOUT_CYCLES; afterwards it is BIT_TIMEOUT_CYCLES.
  - Reaching the limit: release both lines, set Timeout_Err, go to FINISH.
- WAIT_IDLE: wait until synced clock = 1 and data = 1 → FINISH. Exceeding BIT_TIMEOUT_CYCLES sets Timeout_Err → FINISH.
- FINISH (1 cycle): Done = 1, Busy = 0 in the same cycle, both lines released → IDLE.
- Send while Busy = 1 is ignored, with no queueing. Send in the same cycle as FINISH is also ignored; it is accepted from IDLE only.
- Drive outputs are registered and glitch-free. KB_Clk_Drive_Low = 1 only in INHIBIT and START.

Test Plan:
- INHIBIT_CYCLES = 20, timeouts 200/100, device model toggles clock at 40-cycle half period.
  - Send with Tx_Byte = 0xED → clock low for 20 cycles.
  - Device samples on rising edges: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Model ACKs → Done pulse, Ack_Err = 0, Timeout_Err = 0.
- Tx_Byte = 0xFF → parity 1. Tx_Byte = 0x01 → parity 0. Device-sampled frames match.
- Device never clocks → after 200 cycles in WAIT_EDGE: Timeout_Err = 1, Done pulse, both drive outputs 0.
- Device model leaves data high on the 11th clock → Ack_Err = 1, Done pulse.
- A second Send mid-frame is ignored (frame unchanged). Next Send after Done clears Ack_Err in the following cycle.
- Assert Raw_Reset_I low during bit 4 → both drive outputs 0 and Busy 0 before the next clock edge. After reset, a new frame of 0x00 completes correctly.
